// File: rtl/seq_divider_if.sv
// Request/response bundle between the issuing core and the iterative divider.
// The core is the master: it drives the operands and start, the divider answers.
interface seq_divider_if #(
  parameter int N = 18
);
  logic         start;
  logic         signed_op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: one quotient bit per clock on operand magnitudes,
// with signs and the divide-by-zero result applied in a single fix-up cycle.
module seq_divider #(
  parameter int N = 18
) (
  input  logic          clk,
  input  logic          reset_n,
  seq_divider_if.slave  bus
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t        state_q, state_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic          bz_q, bz_d;
  logic [N-1:0]  mag_b_q, mag_b_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  q_out_q, q_out_d;
  logic [N-1:0]  r_out_q, r_out_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    shifted;
  logic [N-1:0]  diff;
  logic          fits;

  function automatic logic [N-1:0] negate(input logic [N-1:0] x);
    return -x;
  endfunction

  // Magnitude of the most-negative value is 2^(N-1), which still fits unsigned in N bits.
  function automatic logic [N-1:0] magnitude(input logic is_signed, input logic [N-1:0] x);
    return (is_signed && x[N-1]) ? negate(x) : x;
  endfunction

  // The partial remainder is always below |b| < 2^N, so the subtraction result fits N bits.
  always_comb begin
    shifted = {rem_q, quo_q[N-1]};
    fits    = (shifted >= {1'b0, mag_b_q});
    diff    = shifted[N-1:0] - mag_b_q;
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    mag_b_d = mag_b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.signed_op & bus.a[N-1];
          sb_d    = bus.signed_op & bus.b[N-1];
          mag_b_d = magnitude(bus.signed_op, bus.b);
          quo_d   = magnitude(bus.signed_op, bus.a);
          rem_d   = '0;
          cnt_d   = '0;
          bz_d    = (bus.b == '0);
          state_d = (bus.b == '0) ? FIX : DIV;
        end
      end
      DIV: begin
        quo_d = {quo_q[N-2:0], fits};
        rem_d = fits ? diff : shifted[N-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // With b==0 the dividend magnitude is still parked in quo_q; re-signing it restores a.
        if (bz_q) begin
          q_out_d = '1;
          r_out_d = sa_q ? negate(quo_q) : quo_q;
          dbz_d   = 1'b1;
        end else begin
          q_out_d = (sa_q ^ sb_q) ? negate(quo_q) : quo_q;
          r_out_d = sa_q ? negate(rem_q) : rem_q;
          dbz_d   = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      mag_b_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      mag_b_q <= mag_b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == DIV) || (state_q == FIX);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = q_out_q;
  assign bus.remainder   = r_out_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed vector table, multi-cycle corner sequences and
// a random sweep against the language's own '/' and '%' operators.
module tb_seq_divider;

  localparam int N  = 18;
  localparam int NV = 15;

  typedef struct {
    logic         s;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    string        name;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  vec_t vecs [NV];

  seq_divider_if #(.N(N)) dif ();

  seq_divider #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic s, input logic [N-1:0] aa, input logic [N-1:0] bb,
                        input logic [N-1:0] eq, input logic [N-1:0] er, input logic edbz,
                        input string nm);
    int cyc;
    int bcnt;
    int exp_lat;
    exp_lat = (bb == '0) ? 1 : N + 1;
    @(negedge clk);
    dif.start     = 1'b1;
    dif.signed_op = s;
    dif.a         = aa;
    dif.b         = bb;
    @(negedge clk);
    dif.start = 1'b0;
    cyc  = 0;
    bcnt = 0;
    while (!dif.done && cyc < 4 * N) begin
      if (dif.busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"},   32'(cyc),  32'(exp_lat));
    chk({nm, " busy_cyc"},  32'(bcnt), 32'(exp_lat));
    chk({nm, " quotient"},  32'(dif.quotient),    32'(eq));
    chk({nm, " remainder"}, 32'(dif.remainder),   32'(er));
    chk({nm, " dbz"},       32'(dif.div_by_zero), 32'(edbz));
    chk({nm, " busy@done"}, 32'(dif.busy),        32'(0));
    @(negedge clk);
    chk({nm, " done_pulse"}, 32'(dif.done), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           ndone;
    int           first_done;
    logic [N-1:0] gq, gr, ra, rb, eq, er;
    logic         rs, edbz;
    logic signed [N-1:0] xa, xb;

    vecs[0]  = '{1'b0, 18'd100,     18'd7,       18'd14,      18'd2,       1'b0, "u_100_7"};
    vecs[1]  = '{1'b1, 18'h3FF9C,   18'd7,       18'h3FFF2,   18'h3FFFE,   1'b0, "s_m100_7"};
    vecs[2]  = '{1'b1, 18'd100,     18'h3FFF9,   18'h3FFF2,   18'd2,       1'b0, "s_100_m7"};
    vecs[3]  = '{1'b1, 18'h3FF9C,   18'h3FFF9,   18'd14,      18'h3FFFE,   1'b0, "s_m100_m7"};
    vecs[4]  = '{1'b0, 18'h12345,   18'd0,       18'h3FFFF,   18'h12345,   1'b1, "u_b0"};
    vecs[5]  = '{1'b1, 18'h12345,   18'd0,       18'h3FFFF,   18'h12345,   1'b1, "s_b0"};
    vecs[6]  = '{1'b1, 18'h3FF9C,   18'd0,       18'h3FFFF,   18'h3FF9C,   1'b1, "s_b0_neg"};
    vecs[7]  = '{1'b1, 18'h20000,   18'h3FFFF,   18'h20000,   18'd0,       1'b0, "s_ovf"};
    vecs[8]  = '{1'b0, 18'h3FFFF,   18'd1,       18'h3FFFF,   18'd0,       1'b0, "u_max_1"};
    vecs[9]  = '{1'b0, 18'h3FFFF,   18'h3FFFF,   18'd1,       18'd0,       1'b0, "u_max_max"};
    vecs[10] = '{1'b0, 18'd5,       18'd9,       18'd0,       18'd5,       1'b0, "u_5_9"};
    vecs[11] = '{1'b1, 18'h3FFFF,   18'd2,       18'd0,       18'h3FFFF,   1'b0, "s_m1_2"};
    vecs[12] = '{1'b0, 18'h20000,   18'h3FFFF,   18'd0,       18'h20000,   1'b0, "u_big_small"};
    vecs[13] = '{1'b1, 18'h20000,   18'd3,       18'h35556,   18'h3FFFE,   1'b0, "s_min_3"};
    vecs[14] = '{1'b0, 18'h3FFFF,   18'h20000,   18'd1,       18'h1FFFF,   1'b0, "u_max_half"};

    dif.start     = 1'b0;
    dif.signed_op = 1'b0;
    dif.a         = '0;
    dif.b         = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(dif.busy),        32'(0));
    chk("rst done", 32'(dif.done),        32'(0));
    chk("rst q",    32'(dif.quotient),    32'(0));
    chk("rst r",    32'(dif.remainder),   32'(0));
    chk("rst dbz",  32'(dif.div_by_zero), 32'(0));
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].name);
    end

    // Re-pulsing start during DIV with new operands must be ignored
    @(negedge clk);
    dif.start = 1'b1; dif.signed_op = 1'b0; dif.a = 18'd100; dif.b = 18'd7;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (4) @(negedge clk);
    dif.start = 1'b1; dif.signed_op = 1'b1; dif.a = 18'd1000; dif.b = 18'd3;
    @(negedge clk);
    dif.start = 1'b0; dif.a = '0; dif.b = '0;
    ndone = 0; gq = '0; gr = '0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (dif.done) begin
        ndone++;
        gq = dif.quotient;
        gr = dif.remainder;
      end
    end
    chk("restart ndone", 32'(ndone), 32'(1));
    chk("restart q",     32'(gq),    32'(14));
    chk("restart r",     32'(gr),    32'(2));

    // Reset in the middle of an iteration aborts the op and clears outputs
    @(negedge clk);
    dif.start = 1'b1; dif.signed_op = 1'b0; dif.a = 18'd1000; dif.b = 18'd3;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst busy", 32'(dif.busy),        32'(0));
    chk("midrst done", 32'(dif.done),        32'(0));
    chk("midrst q",    32'(dif.quotient),    32'(0));
    chk("midrst r",    32'(dif.remainder),   32'(0));
    chk("midrst dbz",  32'(dif.div_by_zero), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (dif.done) ndone++;
    end
    chk("midrst no_done", 32'(ndone), 32'(0));
    run_op(1'b0, 18'd1000, 18'd3, 18'd333, 18'd1, 1'b0, "after_rst");

    // Start held high: ops accepted only from IDLE, one done each
    @(negedge clk);
    dif.start = 1'b1; dif.signed_op = 1'b0; dif.a = 18'd100; dif.b = 18'd7;
    ndone = 0; first_done = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dif.done) begin
        ndone++;
        if (first_done < 0) first_done = i;
        chk("held q", 32'(dif.quotient),  32'(14));
        chk("held r", 32'(dif.remainder), 32'(2));
      end
      if (i == 59) dif.start = 1'b0;
    end
    chk("held ndone", 32'(ndone),      32'(3));
    chk("held first", 32'(first_done), 32'(N + 1));

    // Random sweep against the language operators
    for (int i = 0; i < 1000; i++) begin
      rs = 1'(($urandom_range(0, 1)));
      ra = N'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
      xa = ra;
      xb = rb;
      if (rb == '0) begin
        eq = '1; er = ra; edbz = 1'b1;
      end else if (rs) begin
        eq = xa / xb; er = xa % xb; edbz = 1'b0;
      end else begin
        eq = ra / rb; er = ra % rb; edbz = 1'b0;
      end
      run_op(rs, ra, rb, eq, er, edbz, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
